// File: rtl/arm_mem_pkg.sv
// Shared constants and FSM state type for the MEM-stage SRAM controller.
package arm_mem_pkg;

    localparam int unsigned SRAM_AW         = 18;
    localparam int unsigned SRAM_DW         = 16;
    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_WAIT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_WAIT,
        ST_DONE
    } mem_state_t;

endpackage

// File: rtl/sram_mem_controller.sv
// 32-bit load/store responder executing each access as two 16-bit async SRAM cycles.
// Optional macro SRAM_FAST_WRITE_EN: stores skip the settle wait (HI -> DONE).
module sram_mem_controller
    import arm_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n
);

    mem_state_t state, next_state;

    logic               op_wr;
    logic [16:0]        waddr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         cnt;
    logic [31:0]        addr_diff;
    logic [16:0]        waddr_in;
    logic               unused_addr_bits;

    logic [SRAM_AW-1:0] addr_d;
    logic [SRAM_DW-1:0] dq_out_d;
    logic               dq_oe_d;
    logic               we_n_d;

    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;

    // Out-of-range addresses wrap: only bits [18:2] of the offset are kept.
    assign addr_diff        = address - 32'(BASE_ADDR);
    assign waddr_in         = addr_diff[18:2];
    assign unused_addr_bits = ^{addr_diff[31:19], addr_diff[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (wr_en || rd_en) next_state = ST_LO;
            ST_LO:   next_state = ST_HI;
`ifdef SRAM_FAST_WRITE_EN
            ST_HI:   next_state = op_wr ? ST_DONE : ST_WAIT;
`else
            ST_HI:   next_state = ST_WAIT;
`endif
            ST_WAIT: if (cnt == '0) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Pin values are computed for the upcoming state and registered, so LO can
    // only be entered from IDLE and takes its address/data straight from the request.
    always_comb begin
        ready    = ((state == ST_IDLE) && !(rd_en || wr_en)) || (state == ST_DONE);
        addr_d   = sram_addr;
        dq_out_d = sram_dq_out;
        dq_oe_d  = 1'b0;
        we_n_d   = 1'b1;
        case (next_state)
            ST_LO: begin
                addr_d = {waddr_in, 1'b0};
                if (wr_en) begin
                    dq_out_d = write_data[15:0];
                    dq_oe_d  = 1'b1;
                    we_n_d   = 1'b0;
                end
            end
            ST_HI: begin
                addr_d = {waddr_q, 1'b1};
                if (op_wr) begin
                    dq_out_d = wdata_q[31:16];
                    dq_oe_d  = 1'b1;
                    we_n_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            sram_addr   <= addr_d;
            sram_dq_out <= dq_out_d;
            sram_dq_oe  <= dq_oe_d;
            sram_we_n   <= we_n_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            read_data <= '0;
        end else begin
            if (state == ST_IDLE && (wr_en || rd_en)) begin
                op_wr   <= wr_en;
                waddr_q <= waddr_in;
                wdata_q <= write_data;
            end
            if (state == ST_HI)
                cnt <= 4'(WAIT_CYCLES - 1);
            else if (state == ST_WAIT)
                cnt <= cnt - 4'd1;
            if (state == ST_LO && !op_wr)
                read_data[15:0] <= sram_dq_in;
            if (state == ST_HI && !op_wr)
                read_data[31:16] <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed self-checking bench for sram_mem_controller with a small async SRAM model.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

    logic [15:0] mem [0:63];
    logic        pre_we;
    logic        mem_clr;
    logic [5:0]  pre_idx;
    logic [15:0] pre_val;

    int total = 0;
    int bad   = 0;

`ifdef SRAM_FAST_WRITE_EN
    localparam int STORE_LAT = 3;
`else
    localparam int STORE_LAT = 7;
`endif
    localparam int LOAD_LAT = 7;

    always #5 clk = ~clk;

    sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n)
    );

    // Async SRAM: reads are combinational, writes land at the end of a we_n-low cycle.
    assign sram_dq_in = mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_val;
        end else if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [15:0] val);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issues one request, checks the pin sequence and latency, and returns at the DONE cycle.
    task automatic access(input string tag, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [16:0] exp_waddr,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int lat;
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = addr; write_data = wdata;
        @(negedge clk);
        chk({tag, "_req_ready"}, ready, 0);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) begin
                chk({tag, "_lo_addr"}, sram_addr, {exp_waddr, 1'b0});
                chk({tag, "_lo_we_n"}, sram_we_n, !wr);
                chk({tag, "_lo_oe"}, sram_dq_oe, wr);
                if (wr) chk({tag, "_lo_dq"}, sram_dq_out, wdata[15:0]);
            end
            if (k == 2) begin
                chk({tag, "_hi_addr"}, sram_addr, {exp_waddr, 1'b1});
                if (wr) chk({tag, "_hi_dq"}, sram_dq_out, wdata[31:16]);
            end
            if (ready) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        if (chk_rd) chk({tag, "_rdata"}, read_data, exp_rd);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        address = '0; write_data = '0;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0; mem_clr = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        mem_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe", sram_dq_oe, 0);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_addr", sram_addr, 18'h0);
        chk("rst_dq", sram_dq_out, 16'h0);

        access("st0", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, STORE_LAT, 17'd0, 1'b1, 32'h0);
        chk("st0_mem0", mem[0], 16'hBEEF);
        chk("st0_mem1", mem[1], 16'hDEAD);

        preload(6'd2, 16'h5678);
        preload(6'd3, 16'h1234);
        access("ld1", 1'b0, 1'b1, 32'd1028, 32'h0, LOAD_LAT, 17'd1, 1'b1, 32'h12345678);
        @(negedge clk);
        chk("ld1_hold_idle", read_data, 32'h12345678);

        access("both", 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, STORE_LAT, 17'd2, 1'b1, 32'h12345678);
        chk("both_mem4", mem[4], 16'hF00D);
        chk("both_mem5", mem[5], 16'hCAFE);

        // Word offset 2^17 wraps back to SRAM word 0.
        access("wrap", 1'b0, 1'b1, 32'd1024 + 32'h0008_0000, 32'h0, LOAD_LAT, 17'd0, 1'b1, 32'hDEADBEEF);

        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hAAAA5555;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        chk("rsthi_we_n", sram_we_n, 1);
        chk("rsthi_oe", sram_dq_oe, 0);
        chk("rsthi_rdata", read_data, 32'h0);
        chk("rsthi_ready", ready, 1);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rsthi_we_n_after", sram_we_n, 1);
        chk("rsthi_mem8", mem[8], 16'h5555);
        chk("rsthi_mem9", mem[9], 16'h0000);

        access("ld2", 1'b0, 1'b1, 32'd1028, 32'h0, LOAD_LAT, 17'd1, 1'b1, 32'h12345678);
        access("st3", 1'b1, 1'b0, 32'd1036, 32'h0BAD0CAB, STORE_LAT, 17'd3, 1'b1, 32'h12345678);
        chk("st3_mem6", mem[6], 16'h0CAB);
        chk("st3_mem7", mem[7], 16'h0BAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
